// File: rtl/data_compare_pkg.sv
// data_compare_pkg
//   Shared definitions for the sequential magnitude comparator:
//   one-hot result constants {gt, lt, eq}, FSM state encoding and the
//   cascade-resolution helper used when every chunk compares equal.
package data_compare_pkg;

    // One-hot result encoding shared with the combinational comparator family
    localparam logic [2:0] CMP_GT = 3'b100;
    localparam logic [2:0] CMP_LT = 3'b010;
    localparam logic [2:0] CMP_EQ = 3'b001;

    // FSM state encoding
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Resolve the cascade input once the operands are fully equal.
    // Equality wins, then a lone gt or a lone lt; anything malformed
    // (000, 110) degrades to equal.
    function automatic logic [2:0] resolveCascade(input logic [2:0] cas);
        logic [2:0] res;
        if (cas[0])             res = CMP_EQ;
        else if (cas == CMP_GT) res = CMP_GT;
        else if (cas == CMP_LT) res = CMP_LT;
        else                    res = CMP_EQ;
        return res;
    endfunction

endpackage

// File: rtl/data_compare_chunk.sv
// data_compare_chunk
//   Combinational CHUNK-bit magnitude comparator.
//   Ports:
//     iA, iB    : chunk operands
//     iSigned   : 1 = compare as two's complement, 0 = unsigned
//     oGt, oLt  : A>B, A<B (both low means equal)
module data_compare_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] iA,
    input  logic [CHUNK-1:0] iB,
    input  logic             iSigned,
    output logic             oGt,
    output logic             oLt
);

    // Flipping the sign bit maps two's complement order onto unsigned order,
    // so one unsigned comparator serves both modes.
    logic [CHUNK-1:0] signMask;
    logic [CHUNK-1:0] aAdj;
    logic [CHUNK-1:0] bAdj;

    assign signMask = CHUNK'(iSigned) << (CHUNK - 1);
    assign aAdj     = iA ^ signMask;
    assign bAdj     = iB ^ signMask;
    assign oGt      = aAdj > bAdj;
    assign oLt      = aAdj < bAdj;

endmodule

// File: rtl/data_compare_seq.sv
// data_compare_seq
//   Multi-cycle magnitude comparator: compares two WIDTH-bit operands
//   CHUNK bits per cycle, MSB chunk first, stopping on the first differing
//   chunk. Fully equal operands resolve through the 3-bit cascade input.
//   Optional build macro: DATA_COMPARE_SIGNED_EN (MSB chunk compared as
//   signed, making the whole compare two's complement).
//   Ports:
//     iClk, iRst        : clock, async active-high reset
//     iStart            : request, sampled only in IDLE or DONE
//     iData_a, iData_b  : operands, captured on accept
//     iData             : cascade input {gt, lt, eq}, captured on accept
//     oData             : registered one-hot result, held until next result
//     oBusy             : high while comparing
//     oDone             : one-cycle pulse when oData updates
module data_compare_seq
    import data_compare_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iStart,
    input  logic [WIDTH-1:0] iData_a,
    input  logic [WIDTH-1:0] iData_b,
    input  logic [2:0]       iData,
    output logic [2:0]       oData,
    output logic             oBusy,
    output logic             oDone
);

    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    logic [1:0]                  state;
    logic [KW-1:0]               k;
    logic [N-1:0][CHUNK-1:0]     aReg;
    logic [N-1:0][CHUNK-1:0]     bReg;
    logic [2:0]                  casReg;

    logic [KW-1:0]               chunkIdx;
    logic                        signedChunk;
    logic                        chunkGt;
    logic                        chunkLt;
    logic                        accept;
    logic                        lastChunk;

    // k counts from the MSB chunk, packed index N-1 holds the MSBs
    assign chunkIdx  = KW'(N - 1) - k;
    assign lastChunk = (k == KW'(N - 1));
    assign accept    = iStart && (state == IDLE || state == DONE);

`ifdef DATA_COMPARE_SIGNED_EN
    // Only the MSB chunk carries the sign; lower chunks stay unsigned
    assign signedChunk = (k == '0);
`else
    assign signedChunk = 1'b0;
`endif

    data_compare_chunk #(.CHUNK(CHUNK)) uChunk (
        .iA      (aReg[chunkIdx]),
        .iB      (bReg[chunkIdx]),
        .iSigned (signedChunk),
        .oGt     (chunkGt),
        .oLt     (chunkLt)
    );

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state  <= IDLE;
            k      <= '0;
            aReg   <= '0;
            bReg   <= '0;
            casReg <= CMP_EQ;
            oData  <= CMP_EQ;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        aReg   <= iData_a;
                        bReg   <= iData_b;
                        casReg <= iData;
                        k      <= '0;
                        state  <= RUN;
                    end else begin
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    if (chunkGt || chunkLt) begin
                        oData <= chunkGt ? CMP_GT : CMP_LT;
                        state <= DONE;
                    end else if (lastChunk) begin
                        oData <= resolveCascade(casReg);
                        state <= DONE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign oBusy = (state == RUN);
    assign oDone = (state == DONE);

endmodule

// File: tb/tb_data_compare_seq.sv
module tb_data_compare_seq;

    localparam int WIDTH = 16;
    localparam int CHUNK = 4;

`ifdef DATA_COMPARE_SIGNED_EN
    localparam bit SGN = 1'b1;
`else
    localparam bit SGN = 1'b0;
`endif

    typedef struct {
        string      name;
        logic [2:0] data;
        int         doneCyc;
    } exp_t;

    logic             iClk = 1'b0;
    logic             iRst;
    logic             iStart;
    logic [WIDTH-1:0] iData_a;
    logic [WIDTH-1:0] iData_b;
    logic [2:0]       iData;
    logic [2:0]       oData;
    logic             oBusy;
    logic             oDone;

    data_compare_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .iClk    (iClk),
        .iRst    (iRst),
        .iStart  (iStart),
        .iData_a (iData_a),
        .iData_b (iData_b),
        .iData   (iData),
        .oData   (oData),
        .oBusy   (oBusy),
        .oDone   (oDone)
    );

    always #5 iClk = ~iClk;

    int cyc = 0;
    always @(posedge iClk) cyc <= cyc + 1;

    int   nChecks = 0;
    int   nFails  = 0;
    int   nPushed = 0;
    int   nDone   = 0;
    exp_t sb[$];

    task automatic check(input string nm, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every oDone pulse must match the oldest outstanding request
    always @(negedge iClk) begin
        if (oDone) begin
            nDone++;
            if (sb.size() == 0) begin
                check("spurious_done", int'(oData), -1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_data"}, int'(oData), int'(e.data));
                check({e.name, "_lat"}, cyc, e.doneCyc);
            end
        end
    end

    // Drive one request; returns right after the accepting edge
    task automatic issue(input string nm, input logic [15:0] av, input logic [15:0] bv,
                         input logic [2:0] cv, input logic [2:0] ex, input int lat,
                         input bit expectResult);
        @(negedge iClk);
        iData_a = av;
        iData_b = bv;
        iData   = cv;
        iStart  = 1'b1;
        if (expectResult) begin
            exp_t e;
            e.name    = nm;
            e.data    = ex;
            e.doneCyc = cyc + 1 + lat;
            sb.push_back(e);
            nPushed++;
        end
        @(posedge iClk);
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge iClk);
        check({nm, "_drain"}, sb.size(), 0);
        @(negedge iClk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] cascIn  [4];
        logic [2:0] cascExp [4];
        cascIn  = '{3'b100, 3'b010, 3'b000, 3'b110};
        cascExp = '{3'b100, 3'b010, 3'b001, 3'b001};

        iRst = 1'b1; iStart = 1'b0; iData_a = '0; iData_b = '0; iData = 3'b001;
        #1;
        check("rst_oData", int'(oData), 1);
        check("rst_oBusy", int'(oBusy), 0);
        check("rst_oDone", int'(oDone), 0);
        repeat (2) @(negedge iClk);
        iRst = 1'b0;

        // 1: differ in chunk 1 -> lt after 2 cycles, busy for 2 cycles
        issue("t1", 16'h1234, 16'h1334, 3'b001, 3'b010, 2, 1'b1);
        @(negedge iClk); iStart = 1'b0;
        check("t1_busy0", int'(oBusy), 1);
        @(negedge iClk);
        check("t1_busy1", int'(oBusy), 1);
        @(negedge iClk);
        check("t1_busy2", int'(oBusy), 0);
        drain("t1");

        // 2: MSB chunk decides; sign changes the answer
        issue("t2", 16'hF000, 16'h0FFF, 3'b001, SGN ? 3'b010 : 3'b100, 1, 1'b1);
        @(negedge iClk); iStart = 1'b0;
        drain("t2");

        // 3: equal operands resolve through the cascade
        for (int i = 0; i < 4; i++) begin
            issue("t3", 16'hABCD, 16'hABCD, cascIn[i], cascExp[i], 4, 1'b1);
            @(negedge iClk); iStart = 1'b0;
            drain("t3");
        end

        // 4: start during RUN is ignored
        issue("t4", 16'h0001, 16'h0002, 3'b001, 3'b010, 4, 1'b1);
        @(negedge iClk); iStart = 1'b0;
        @(negedge iClk); iData_a = 16'hFFFF; iStart = 1'b1;
        @(negedge iClk); iStart = 1'b0;
        drain("t4");

        // 5: reset mid-compare aborts, no result
        issue("t5a", 16'hABCD, 16'hABCD, 3'b100, 3'b100, 4, 1'b0);
        @(negedge iClk); iStart = 1'b0;
        @(negedge iClk);
        #1 iRst = 1'b1;
        #1;
        check("t5_rst_busy", int'(oBusy), 0);
        check("t5_rst_oData", int'(oData), 1);
        check("t5_rst_done", int'(oDone), 0);
        @(negedge iClk); iRst = 1'b0;
        issue("t5b", 16'h8000, 16'h7FFF, 3'b001, SGN ? 3'b010 : 3'b100, 1, 1'b1);
        @(negedge iClk); iStart = 1'b0;
        drain("t5");

        // 6: iStart held, new pair accepted in the DONE cycle
        issue("t6a", 16'hF000, 16'h0FFF, 3'b001, SGN ? 3'b010 : 3'b100, 1, 1'b1);
        @(posedge iClk);
        issue("t6b", 16'h0010, 16'h0020, 3'b001, 3'b010, 3, 1'b1);
        @(negedge iClk); iStart = 1'b0;
        check("t6_b2b_busy", int'(oBusy), 1);
        drain("t6");

        check("done_count", nDone, nPushed);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
